// File: rtl/tt_mux_ctrl_seq.sv
// tt_mux_ctrl_seq: drives the project mux address counter (reset + inc
// pulses) to reach a requested address, then re-enables the project.
module tt_mux_ctrl_seq #(
  parameter int ADDR_W    = 10,
  parameter int RST_CYC   = 4,
  parameter int GAP_CYC   = 2,
  parameter int PULSE_CYC = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  input  logic              dis_req,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_valid
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DIS  = 3'd1;
  localparam logic [2:0] S_RST  = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_HI   = 3'd4;
  localparam logic [2:0] S_LO   = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;

  localparam int TMAX_RG = (RST_CYC > GAP_CYC) ? RST_CYC : GAP_CYC;
  localparam int TMAX    = (TMAX_RG > PULSE_CYC) ? TMAX_RG : PULSE_CYC;
  localparam int TW      = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_RST = TW'(RST_CYC - 1);
  localparam logic [TW-1:0] T_GAP = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] T_PUL = TW'(PULSE_CYC - 1);

  logic [2:0]        r_state;
  logic [TW-1:0]     r_tmr;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_tgt;
  logic              r_ena;
  logic [ADDR_W-1:0] r_cur;
  logic              r_cval;
  logic              r_rst_n;
  logic              r_inc;
  logic              r_cena;
  logic              r_busy;
  logic              r_done;

  logic [2:0]        w_nxt;
  logic [TW-1:0]     w_tmr;
  logic [ADDR_W-1:0] w_cnt;
  logic [ADDR_W-1:0] w_cur;
  logic              w_cval;
  logic              w_accept;
  logic              w_tdone;
  logic              w_rpath;
  logic [ADDR_W-1:0] w_diff;

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_tdone   = (r_tmr == '0);
  assign w_rpath   = !r_cval || (r_tgt < r_cur);
  assign w_diff    = r_tgt - r_cur;

  // next state, phase timer, remaining increments and address tracking
  always_comb begin
    w_nxt  = r_state;
    w_tmr  = r_tmr;
    w_cnt  = r_cnt;
    w_cur  = r_cur;
    w_cval = r_cval;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_nxt = S_DIS;
        end
      end
      S_DIS: begin
        if (w_rpath) begin
          w_nxt = S_RST;
          w_tmr = T_RST;
          w_cnt = r_tgt;
        end else begin
          w_cnt = w_diff;
          w_tmr = T_PUL;
          w_nxt = (w_diff == '0) ? S_FIN : S_HI;
        end
      end
      S_RST: begin
        if (w_tdone) begin
          w_cur  = '0;
          w_cval = 1'b1;
          w_nxt  = S_GAP;
          w_tmr  = T_GAP;
        end else begin
          w_tmr = r_tmr - 1'b1;
        end
      end
      S_GAP: begin
        if (w_tdone) begin
          w_nxt = (r_cnt == '0) ? S_FIN : S_HI;
          w_tmr = T_PUL;
        end else begin
          w_tmr = r_tmr - 1'b1;
        end
      end
      S_HI: begin
        if (w_tdone) begin
          w_cur = r_cur + 1'b1;
          w_cnt = r_cnt - 1'b1;
          w_nxt = S_LO;
          w_tmr = T_PUL;
        end else begin
          w_tmr = r_tmr - 1'b1;
        end
      end
      S_LO: begin
        if (w_tdone) begin
          w_nxt = (r_cnt == '0) ? S_FIN : S_HI;
          w_tmr = T_PUL;
        end else begin
          w_tmr = r_tmr - 1'b1;
        end
      end
      S_FIN: begin
        w_nxt = S_IDLE;
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
  end

  // state, counters and request capture
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_cnt   <= '0;
      r_tgt   <= '0;
      r_ena   <= 1'b0;
      r_cur   <= '0;
      r_cval  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_tmr   <= w_tmr;
      r_cnt   <= w_cnt;
      r_cur   <= w_cur;
      r_cval  <= w_cval;
      if (w_accept) begin
        r_tgt <= req_addr;
        r_ena <= req_ena;
      end
    end
  end

  // outputs registered from the state being entered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rst_n <= 1'b1;
      r_inc   <= 1'b0;
      r_cena  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_rst_n <= (w_nxt != S_RST);
      r_inc   <= (w_nxt == S_HI);
      r_busy  <= (w_nxt != S_IDLE);
      r_done  <= (w_nxt == S_FIN);
      if (w_nxt == S_DIS) begin
        r_cena <= 1'b0;
      end else if (w_nxt == S_FIN) begin
        r_cena <= r_ena;
      end else if (r_state == S_IDLE && dis_req) begin
        r_cena <= 1'b0;
      end
    end
  end

  assign ctrl_sel_rst_n = r_rst_n;
  assign ctrl_sel_inc   = r_inc;
  assign ctrl_ena       = r_cena;
  assign busy           = r_busy;
  assign done           = r_done;
  assign cur_addr       = r_cur;
  assign cur_valid      = r_cval;

endmodule

// File: tb/tb_tt_mux_ctrl_seq.sv
// tb_tt_mux_ctrl_seq: randomized requests, scoreboard of expected
// sequence outcomes from a high-level model, plus directed corner cases.
module tb_tt_mux_ctrl_seq;

  localparam int AW  = 10;
  localparam int RC  = 4;
  localparam int GC  = 2;
  localparam int PC  = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_ena;
  logic          dis_req;
  logic          ctrl_sel_rst_n;
  logic          ctrl_sel_inc;
  logic          ctrl_ena;
  logic          busy;
  logic          done;
  logic [AW-1:0] cur_addr;
  logic          cur_valid;

  tt_mux_ctrl_seq #(
    .ADDR_W(AW), .RST_CYC(RC), .GAP_CYC(GC), .PULSE_CYC(PC)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_ena(req_ena), .dis_req(dis_req),
    .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc),
    .ctrl_ena(ctrl_ena), .busy(busy), .done(done),
    .cur_addr(cur_addr), .cur_valid(cur_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    bit ena;
    int dcyc;
    int ninc;
    int nrl;
    int nel;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int m_addr = 0;
  bit m_valid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // model: derive a request's outcome from the address rules
  task automatic send(input int a, input bit e, input bit d);
    int k;
    bit rp;
    int n;
    exp_t x;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 10000) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", req_ready, 1);
    rp = !m_valid || (a < m_addr);
    n = rp ? a : a - m_addr;
    x.addr = a;
    x.ena  = e;
    x.ninc = n;
    x.nrl  = rp ? RC : 0;
    x.nel  = 1 + (rp ? RC + GC : 0) + n * 2 * PC;
    x.dcyc = cyc + x.nel + 1;
    m_addr = a;
    m_valid = 1;
    sb.push_back(x);
    req_valid = 1'b1;
    req_addr  = AW'(a);
    req_ena   = e;
    dis_req   = d;
    @(negedge clk);
    req_valid = 1'b0;
    dis_req   = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || !req_ready) && k < 10000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", busy, 0);
  endtask

  task automatic noise();
    int k;
    k = 0;
    while (busy && k < 200) begin
      req_valid = 1'b1;
      req_addr  = AW'($urandom);
      dis_req   = 1'($urandom_range(0, 1));
      @(negedge clk);
      k++;
    end
    req_valid = 1'b0;
    dis_req   = 1'b0;
  endtask

  int n_inc = 0;
  int n_rl  = 0;
  int n_el  = 0;
  bit p_inc = 0;

  // monitor: tally pulses and check each completed sequence
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      sb.delete();
      n_inc = 0;
      n_rl  = 0;
      n_el  = 0;
      p_inc = 0;
    end else begin
      if (ctrl_sel_inc && !p_inc) n_inc++;
      p_inc = ctrl_sel_inc;
      if (!ctrl_sel_rst_n) n_rl++;
      if (busy && !done && !ctrl_ena) n_el++;
      chk("inc_vs_rst", ctrl_sel_inc && !ctrl_sel_rst_n, 0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 0, 1);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.dcyc);
          chk("cur_addr", cur_addr, e.addr);
          chk("cur_valid", cur_valid, 1);
          chk("ctrl_ena", ctrl_ena, e.ena);
          chk("inc_pulses", n_inc, e.ninc);
          chk("rst_low_cyc", n_rl, e.nrl);
          chk("ena_low_cyc", n_el, e.nel);
        end
        n_inc = 0;
        n_rl  = 0;
        n_el  = 0;
      end
    end
  end

  task automatic chk_rst_outs(input string tag);
    chk({tag, "_rst_n"}, ctrl_sel_rst_n, 1);
    chk({tag, "_inc"}, ctrl_sel_inc, 0);
    chk({tag, "_ena"}, ctrl_ena, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_addr"}, cur_addr, 0);
    chk({tag, "_cval"}, cur_valid, 0);
    chk({tag, "_ready"}, req_ready, 1);
  endtask

  initial begin
    int k;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_ena   = 1'b0;
    dis_req   = 1'b0;
    repeat (3) @(negedge clk);
    chk_rst_outs("reset");
    reset_n = 1'b1;

    send(3, 1, 0);
    send(5, 1, 0);
    send(2, 1, 0);
    send(2, 1, 0);
    wait_idle();

    chk("ena_before_dis", ctrl_ena, 1);
    dis_req = 1'b1;
    @(negedge clk);
    dis_req = 1'b0;
    chk("dis_idle_ena", ctrl_ena, 0);
    chk("dis_idle_busy", busy, 0);

    send(4, 1, 1);
    send(9, 1, 0);
    noise();
    send(1, 1, 0);
    noise();

    for (int i = 0; i < 25; i++) begin
      send($urandom_range(0, 40), $urandom_range(0, 3) != 0, 0);
    end

    send(0, 1, 0);
    send(1023, 1, 0);
    send(10, 1, 0);
    k = 0;
    while (!ctrl_sel_inc && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("saw_inc_hi", ctrl_sel_inc, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk_rst_outs("abort");
    reset_n = 1'b1;
    m_addr  = 0;
    m_valid = 0;
    send(1, 1, 0);
    wait_idle();
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
